// File: rtl/div_seq_if.sv
// Start/busy/done handshake bundle between a divide requester and div_seq.
// Latency: none, this file only holds wires.
// Backpressure: none; the requester must watch busy_o/done_o before starting.
interface div_seq_if #(
  parameter int DW_N = 16,
  parameter int DW_D = 8
);

  logic            start_i;
  logic [DW_N-1:0] dividend_i;
  logic [DW_D-1:0] divisor_i;
  logic            busy_o;
  logic            done_o;
  logic            div0_o;
  logic [DW_N-1:0] quotient_o;
  logic [DW_D-1:0] remainder_o;

  // Requester side: drives the request, observes status and results.
  modport master (
    output start_i, dividend_i, divisor_i,
    input  busy_o, done_o, div0_o, quotient_o, remainder_o
  );

  // Divider side.
  modport slave (
    input  start_i, dividend_i, divisor_i,
    output busy_o, done_o, div0_o, quotient_o, remainder_o
  );

endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider: DW_N-bit dividend / DW_D-bit divisor, one quotient bit per clock.
// Latency: done_o pulses DW_N edges after the start edge (cycle after the start edge for divisor 0).
// Backpressure: none; start_i is only sampled in IDLE and ignored while busy or done.
module div_seq #(
  parameter int DW_N = 16,
  parameter int DW_D = 8
) (
  input  logic       clk,
  input  logic       rstn,
  div_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(DW_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;

  // Dividend bits shift out of the MSB while quotient bits shift into the LSB,
  // so after DW_N steps this register holds the quotient.
  logic [DW_N-1:0] dvd_q;
  logic [DW_D-1:0] dvs_q;
  logic [DW_D-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  // Registered outputs.
  logic            busy_q;
  logic            done_q;
  logic            div0_q;
  logic [DW_N-1:0] quot_q;
  logic [DW_D-1:0] remd_q;

  // One restoring step.
  logic [DW_D:0]   trial;
  logic [DW_D:0]   dvs_ext;
  logic            q_bit;
  logic [DW_D-1:0] rem_nxt;
  logic [DW_N-1:0] dvd_nxt;

  // One restoring iteration: compare at DW_D+1 bits so the shifted-in partial remainder never overflows.
  always_comb begin
    trial   = {rem_q, dvd_q[DW_N-1]};
    dvs_ext = {1'b0, dvs_q};
    q_bit   = (trial >= dvs_ext);
    // When the subtraction happens, trial < 2*divisor, so the difference fits in DW_D bits.
    rem_nxt = q_bit ? DW_D'(trial - dvs_ext) : trial[DW_D-1:0];
    dvd_nxt = (dvd_q << 1) | DW_N'(q_bit);
  end

  // Control FSM, iteration datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      quot_q <= '0;
      remd_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.divisor_i != '0) begin
              state  <= CALC;
              busy_q <= 1'b1;
              dvd_q  <= bus.dividend_i;
              dvs_q  <= bus.divisor_i;
              rem_q  <= '0;
              cnt_q  <= CNT_W'(DW_N);
            end else begin
              // Divide by zero short-circuits straight to DONE with saturated quotient.
              state  <= DONE;
              done_q <= 1'b1;
              div0_q <= 1'b1;
              quot_q <= '1;
              remd_q <= '0;
            end
          end
        end

        CALC: begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // Final bit: load results from the step outputs so they are valid with done_o.
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            div0_q <= 1'b0;
            quot_q <= dvd_nxt;
            remd_q <= rem_nxt;
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.div0_o      = div0_q;
  assign bus.quotient_o  = quot_q;
  assign bus.remainder_o = remd_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results queued at start, compared when done_o pulses.
// Covers reset, basic/corner divides, divide by zero, held start, mid-op reset and random ops.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_div_seq;

  logic clk;
  logic rstn;

  div_seq_if #(.DW_N(16), .DW_D(8)) bus ();

  div_seq #(.DW_N(16), .DW_D(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        d0;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;
  int   lat;
  int   bcnt;
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue the reference result and drive start for the E0 edge; returns at the falling edge after E0.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    exp_t x;
    if (b == 8'd0) begin
      x.q = 16'hFFFF; x.r = 8'd0; x.d0 = 1'b1;
    end else begin
      x.q = a / 16'(b); x.r = 8'(a % 16'(b)); x.d0 = 1'b0;
    end
    sb.push_back(x);
    bus.start_i    = 1'b1;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.dividend_i = 16'($urandom);
    bus.divisor_i  = 8'($urandom);
  endtask

  // Edges after E0 until done_o is seen (bounded), counting busy cycles on the way.
  task automatic wait_done(output int l, output int bc);
    l = 0; bc = 0;
    while (bus.done_o !== 1'b1 && l < 40) begin
      if (bus.busy_o === 1'b1) bc++;
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.start_i = 1'b0; bus.dividend_i = '0; bus.divisor_i = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.done_o !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done_o); else n_pass++;
    n_checks++; if (bus.div0_o !== 1'b0) $display("FAIL reset_div0 got %b want 0", bus.div0_o); else n_pass++;
    n_checks++; if (bus.quotient_o !== 16'd0) $display("FAIL reset_q got %h want 0", bus.quotient_o); else n_pass++;
    n_checks++; if (bus.remainder_o !== 8'd0) $display("FAIL reset_r got %h want 0", bus.remainder_o); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    issue(16'd100, 8'd7);
    wait_done(lat, bcnt);
    e = sb.pop_front();
    n_checks++; if (lat != 16) $display("FAIL basic_latency got %0d want 16", lat); else n_pass++;
    n_checks++; if (bcnt != 16) $display("FAIL basic_busy_cycles got %0d want 16", bcnt); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.quotient_o !== 16'd14 || bus.quotient_o !== e.q) $display("FAIL basic_q got %0d want 14", bus.quotient_o); else n_pass++;
    n_checks++; if (bus.remainder_o !== 8'd2 || bus.remainder_o !== e.r) $display("FAIL basic_r got %0d want 2", bus.remainder_o); else n_pass++;
    n_checks++; if (bus.div0_o !== 1'b0) $display("FAIL basic_div0 got %b want 0", bus.div0_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0) $display("FAIL basic_done_width got %b want 0", bus.done_o); else n_pass++;
    n_checks++; if (bus.quotient_o !== 16'd14 || bus.remainder_o !== 8'd2)
      $display("FAIL basic_hold got q=%0d r=%0d want q=14 r=2", bus.quotient_o, bus.remainder_o); else n_pass++;
  endtask

  task automatic test_corner;
    logic [15:0] a_tab [3];
    logic [7:0]  b_tab [3];
    logic [15:0] q_tab [3];
    logic [7:0]  r_tab [3];
    a_tab = '{16'd65025, 16'hFFFF, 16'd5};
    b_tab = '{8'd255,    8'd1,     8'd200};
    q_tab = '{16'd255,   16'hFFFF, 16'd0};
    r_tab = '{8'd0,      8'd0,     8'd5};
    for (int i = 0; i < 3; i++) begin
      issue(a_tab[i], b_tab[i]);
      wait_done(lat, bcnt);
      e = sb.pop_front();
      n_checks++; if (lat != 16) $display("FAIL corner%0d_latency got %0d want 16", i, lat); else n_pass++;
      n_checks++; if (bus.quotient_o !== q_tab[i] || e.q !== q_tab[i])
        $display("FAIL corner%0d_q got %h want %h", i, bus.quotient_o, q_tab[i]); else n_pass++;
      n_checks++; if (bus.remainder_o !== r_tab[i] || e.r !== r_tab[i])
        $display("FAIL corner%0d_r got %h want %h", i, bus.remainder_o, r_tab[i]); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_div0;
    issue(16'd1234, 8'd0);
    wait_done(lat, bcnt);
    e = sb.pop_front();
    n_checks++; if (lat != 0) $display("FAIL div0_latency got %0d want 0", lat); else n_pass++;
    n_checks++; if (bcnt != 0 || bus.busy_o !== 1'b0) $display("FAIL div0_busy got %0d cycles want 0", bcnt); else n_pass++;
    n_checks++; if (bus.div0_o !== e.d0) $display("FAIL div0_flag got %b want %b", bus.div0_o, e.d0); else n_pass++;
    n_checks++; if (bus.quotient_o !== e.q) $display("FAIL div0_q got %h want %h", bus.quotient_o, e.q); else n_pass++;
    n_checks++; if (bus.remainder_o !== e.r) $display("FAIL div0_r got %h want %h", bus.remainder_o, e.r); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL div0_after got done=%b busy=%b want 0 0", bus.done_o, bus.busy_o); else n_pass++;
  endtask

  task automatic test_start_held;
    exp_t x;
    x.q = 16'd14; x.r = 8'd2; x.d0 = 1'b0;
    sb.push_back(x);
    bus.start_i = 1'b1; bus.dividend_i = 16'd100; bus.divisor_i = 8'd7;
    @(posedge clk);
    @(negedge clk);
    // start stays high; operands change while the first op is in flight.
    bus.dividend_i = 16'd200; bus.divisor_i = 8'd9;
    wait_done(lat, bcnt);
    e = sb.pop_front();
    n_checks++; if (lat != 16) $display("FAIL held1_latency got %0d want 16", lat); else n_pass++;
    n_checks++; if (bus.quotient_o !== e.q || bus.remainder_o !== e.r)
      $display("FAIL held1_result got q=%0d r=%0d want q=%0d r=%0d", bus.quotient_o, bus.remainder_o, e.q, e.r); else n_pass++;
    n_checks++; if (bus.div0_o !== 1'b0) $display("FAIL held1_div0 got %b want 0", bus.div0_o); else n_pass++;
    @(negedge clk);
    x.q = 16'd22; x.r = 8'd2; x.d0 = 1'b0;
    sb.push_back(x);
    n_checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0)
      $display("FAIL held_idle got busy=%b done=%b want 0 0", bus.busy_o, bus.done_o); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    n_checks++; if (bus.busy_o !== 1'b1) $display("FAIL held2_started got busy=%b want 1", bus.busy_o); else n_pass++;
    wait_done(lat, bcnt);
    e = sb.pop_front();
    n_checks++; if (lat != 16) $display("FAIL held2_latency got %0d want 16", lat); else n_pass++;
    n_checks++; if (bus.quotient_o !== e.q || bus.remainder_o !== e.r)
      $display("FAIL held2_result got q=%0d r=%0d want q=%0d r=%0d", bus.quotient_o, bus.remainder_o, e.q, e.r); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(16'd1000, 8'd3);
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    #1;
    void'(sb.pop_front());
    n_checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.div0_o !== 1'b0)
      $display("FAIL midrst_flags got busy=%b done=%b div0=%b want 0 0 0", bus.busy_o, bus.done_o, bus.div0_o); else n_pass++;
    n_checks++; if (bus.quotient_o !== 16'd0 || bus.remainder_o !== 8'd0)
      $display("FAIL midrst_results got q=%h r=%h want 0 0", bus.quotient_o, bus.remainder_o); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL midrst_no_done got %0d active cycles want 0", seen); else n_pass++;
    issue(16'd50, 8'd3);
    wait_done(lat, bcnt);
    e = sb.pop_front();
    n_checks++; if (lat != 16) $display("FAIL midrst_new_latency got %0d want 16", lat); else n_pass++;
    n_checks++; if (bus.quotient_o !== 16'd16 || bus.remainder_o !== 8'd2 || e.q !== 16'd16)
      $display("FAIL midrst_new_result got q=%0d r=%0d want q=16 r=2", bus.quotient_o, bus.remainder_o); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [7:0]  b;
    logic [31:0] recon;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      if (i % 8 == 0) a = 16'($urandom_range(0, 300));
      issue(a, b);
      wait_done(lat, bcnt);
      e = sb.pop_front();
      n_checks++; if (bus.quotient_o !== e.q || bus.remainder_o !== e.r)
        $display("FAIL rand%0d_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                 i, a, b, bus.quotient_o, bus.remainder_o, e.q, e.r); else n_pass++;
      recon = 32'(bus.quotient_o) * 32'(b) + 32'(bus.remainder_o);
      n_checks++; if (recon !== 32'(a) || bus.remainder_o >= b)
        $display("FAIL rand%0d_invariant %0d/%0d got q*d+r=%0d r=%0d want %0d with r<d",
                 i, a, b, recon, bus.remainder_o, a); else n_pass++;
      n_checks++; if (lat != 16) $display("FAIL rand%0d_latency got %0d want 16", i, lat); else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_corner();
    test_div0();
    test_start_held();
    test_reset_mid();
    test_random();
    n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_empty got %0d entries want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
